bank_cmd_scheduler: RTL and testbench

//  Upstream of command_sender. Takes one memory request at a time over a valid/ready handshake.

---
 rtl/mem_ctrl_pkg.sv | 53 +++++
 rtl/address_parser.sv | 26 ++
 rtl/bank_cmd_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_bank_cmd_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and timing constants for the memory-controller command path.
package mem_ctrl_pkg;

   localparam int CAS_LATENCY        = 22;
   localparam int ACTIVATION_LATENCY = 8;
   localparam int PRECHARGE_LATENCY  = 5;
   localparam int BURST_LEN          = 8;
   localparam int BANK_GROUPS        = 2;
   localparam int BANKS_PER_GROUP    = 4;
   localparam int ROW_BITS           = 8;
   localparam int COL_BITS           = 4;
   localparam int PADDR_BITS         = 19;
   localparam int OFFSET_BITS        = 2;
   localparam int DATA_BITS          = 64;

   localparam int BG_BITS       = $clog2(BANK_GROUPS);
   localparam int BA_BITS       = $clog2(BANKS_PER_GROUP);
   localparam int BANK_IDX_BITS = BG_BITS + BA_BITS;
   localparam int NUM_BANKS     = BANK_GROUPS * BANKS_PER_GROUP;

   // Wide enough for the longest wait (CAS + burst - 1).
   localparam int CNT_BITS = 5;

   typedef enum logic [2:0] {
      CMD_READ      = 3'd0,
      CMD_WRITE     = 3'd1,
      CMD_ACTIVATE  = 3'd2,
      CMD_PRECHARGE = 3'd3,
      CMD_NOP       = 3'd7
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE_PRE,
      ST_WAIT_PRE,
      ST_ISSUE_ACT,
      ST_WAIT_ACT,
      ST_ISSUE_RW,
      ST_WAIT_RW
   } sched_state_e;

   typedef struct packed {
      logic                                write;
      logic [PADDR_BITS-1:0]               addr;
      logic [BURST_LEN-1:0][DATA_BITS-1:0] data;
   } req_t;

   // Down-counter preload so the next command lands exactly lat cycles after the last.
   function automatic logic [CNT_BITS-1:0] wait_load(input int lat);
      return CNT_BITS'(lat - 1);
   endfunction

endpackage

// File: rtl/address_parser.sv
// Splits a word address {row, bg, ba, col, offset} into its DRAM fields.
module address_parser
   import mem_ctrl_pkg::*;
(
   input  logic [PADDR_BITS-1:0] addr_i,
   output logic [BG_BITS-1:0]    bg_o,
   output logic [BA_BITS-1:0]    ba_o,
   output logic [ROW_BITS-1:0]   row_o,
   output logic [COL_BITS-1:0]   col_o
);

   localparam int COL_LSB = OFFSET_BITS;
   localparam int BA_LSB  = COL_LSB + COL_BITS;
   localparam int BG_LSB  = BA_LSB + BA_BITS;
   localparam int ROW_LSB = BG_LSB + BG_BITS;

   assign col_o = addr_i[COL_LSB +: COL_BITS];
   assign ba_o  = addr_i[BA_LSB +: BA_BITS];
   assign bg_o  = addr_i[BG_LSB +: BG_BITS];
   assign row_o = addr_i[ROW_LSB +: ROW_BITS];

   // Byte offset and bits above the row field carry no command information.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_i[PADDR_BITS-1:ROW_LSB+ROW_BITS], addr_i[OFFSET_BITS-1:0]};

endmodule

// File: rtl/bank_cmd_scheduler.sv
// Per-request DRAM command sequencer with open-row tracking and hit/miss counters.
//
//  state     | meaning
//  IDLE      | ready for a request; decode hit/closed/conflict on accept
//  ISSUE_PRE | PRECHARGE visible this cycle, closes the bank's row
//  WAIT_PRE  | spacing after PRECHARGE
//  ISSUE_ACT | ACTIVATE visible this cycle, opens the requested row
//  WAIT_ACT  | spacing after ACTIVATE
//  ISSUE_RW  | READ or WRITE visible this cycle
//  WAIT_RW   | burst (plus CAS for reads) in flight
module bank_cmd_scheduler
   import mem_ctrl_pkg::*;
(
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic                                req_valid_in,
   output logic                                req_ready_out,
   input  logic                                req_write_in,
   input  logic [PADDR_BITS-1:0]               req_addr_in,
   input  logic [BURST_LEN-1:0][DATA_BITS-1:0] req_data_in,
   output logic [BG_BITS-1:0]                  bank_group_out,
   output logic [BA_BITS-1:0]                  bank_out,
   output logic [ROW_BITS-1:0]                 row_out,
   output logic [COL_BITS-1:0]                 col_out,
   output logic [2:0]                          cmd_out,
   output logic                                valid_out,
   output logic [BURST_LEN-1:0][DATA_BITS-1:0] val_out,
   output logic [31:0]                         hit_count_out,
   output logic [31:0]                         miss_count_out
);

   sched_state_e state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   req_t req_q, req_d;
   logic accept;

   logic [BG_BITS-1:0]       bg;
   logic [BA_BITS-1:0]       ba;
   logic [ROW_BITS-1:0]      row;
   logic [COL_BITS-1:0]      col;
   logic [BANK_IDX_BITS-1:0] bank_idx;

   logic [NUM_BANKS-1:0] open_vld_q;
   logic [ROW_BITS-1:0]  open_row_q [NUM_BANKS];
   logic row_open, row_hit;

   cmd_e cmd_d, cmd_q;
   logic issue_d, valid_q;
   logic [BG_BITS-1:0]  bg_q;
   logic [BA_BITS-1:0]  ba_q;
   logic [ROW_BITS-1:0] row_q;
   logic [COL_BITS-1:0] col_q;
   logic [BURST_LEN-1:0][DATA_BITS-1:0] val_q;
   logic [31:0] hit_q, miss_q;

   assign accept = (state_q == ST_IDLE) && req_valid_in;
   // On the accept cycle the fields come straight from the inputs so the first command needs no extra cycle.
   assign req_d  = accept ? '{write: req_write_in, addr: req_addr_in, data: req_data_in} : req_q;

   address_parser u_address_parser (
      .addr_i (req_d.addr),
      .bg_o   (bg),
      .ba_o   (ba),
      .row_o  (row),
      .col_o  (col)
   );

   assign bank_idx = {bg, ba};
   assign row_open = open_vld_q[bank_idx];
   assign row_hit  = row_open && (open_row_q[bank_idx] == row);

   // Next state, wait preload and the command to present in the next cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = CMD_NOP;
      issue_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_in) begin
               if (row_hit)       state_d = ST_ISSUE_RW;
               else if (row_open) state_d = ST_ISSUE_PRE;
               else               state_d = ST_ISSUE_ACT;
            end
         end
         ST_ISSUE_PRE: begin
            state_d = ST_WAIT_PRE;
            cnt_d   = wait_load(PRECHARGE_LATENCY);
         end
         ST_WAIT_PRE: begin
            if (cnt_q == CNT_BITS'(1)) state_d = ST_ISSUE_ACT;
            else                       cnt_d   = cnt_q - CNT_BITS'(1);
         end
         ST_ISSUE_ACT: begin
            state_d = ST_WAIT_ACT;
            cnt_d   = wait_load(ACTIVATION_LATENCY);
         end
         ST_WAIT_ACT: begin
            if (cnt_q == CNT_BITS'(1)) state_d = ST_ISSUE_RW;
            else                       cnt_d   = cnt_q - CNT_BITS'(1);
         end
         ST_ISSUE_RW: begin
            state_d = ST_WAIT_RW;
            cnt_d   = req_q.write ? wait_load(BURST_LEN) : wait_load(CAS_LATENCY + BURST_LEN);
         end
         ST_WAIT_RW: begin
            if (cnt_q == CNT_BITS'(1)) state_d = ST_IDLE;
            else                       cnt_d   = cnt_q - CNT_BITS'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      unique case (state_d)
         ST_ISSUE_PRE: begin cmd_d = CMD_PRECHARGE; issue_d = 1'b1; end
         ST_ISSUE_ACT: begin cmd_d = CMD_ACTIVATE;  issue_d = 1'b1; end
         ST_ISSUE_RW:  begin cmd_d = req_d.write ? CMD_WRITE : CMD_READ; issue_d = 1'b1; end
         default:      begin cmd_d = CMD_NOP;       issue_d = 1'b0; end
      endcase
   end

   // FSM state, wait counter and latched request.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
      end
   end

   // Open-row table follows the PRECHARGE/ACTIVATE being driven this cycle.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         open_vld_q <= '0;
         for (int i = 0; i < NUM_BANKS; i++) open_row_q[i] <= '0;
      end else if (state_q == ST_ISSUE_PRE) begin
         open_vld_q[bank_idx] <= 1'b0;
      end else if (state_q == ST_ISSUE_ACT) begin
         open_vld_q[bank_idx] <= 1'b1;
         open_row_q[bank_idx] <= row;
      end
   end

   // Registered command outputs; address and write data hold between commands.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cmd_q   <= CMD_NOP;
         valid_q <= 1'b0;
         bg_q    <= '0;
         ba_q    <= '0;
         row_q   <= '0;
         col_q   <= '0;
         val_q   <= '0;
      end else begin
         cmd_q   <= cmd_d;
         valid_q <= issue_d;
         if (issue_d) begin
            bg_q  <= bg;
            ba_q  <= ba;
            row_q <= row;
            col_q <= col;
         end
         if (cmd_d == CMD_WRITE) val_q <= req_d.data;
      end
   end

   // Saturating row-hit / row-miss statistics, classified at accept.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (accept) begin
         if (row_hit) begin
            if (hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
         end else begin
            if (miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
         end
      end
   end

   assign req_ready_out  = (state_q == ST_IDLE);
   assign cmd_out        = cmd_q;
   assign valid_out      = valid_q;
   assign bank_group_out = bg_q;
   assign bank_out       = ba_q;
   assign row_out        = row_q;
   assign col_out        = col_q;
   assign val_out        = val_q;
   assign hit_count_out  = hit_q;
   assign miss_count_out = miss_q;

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Directed bench for bank_cmd_scheduler with hand-computed command timing.
module tb_bank_cmd_scheduler;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic              req_valid_in;
   logic              req_ready_out;
   logic              req_write_in;
   logic [18:0]       req_addr_in;
   logic [7:0][63:0]  req_data_in;
   logic [0:0]        bank_group_out;
   logic [1:0]        bank_out;
   logic [7:0]        row_out;
   logic [3:0]        col_out;
   logic [2:0]        cmd_out;
   logic              valid_out;
   logic [7:0][63:0]  val_out;
   logic [31:0]       hit_count_out;
   logic [31:0]       miss_count_out;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int ncmd   = 0;
   int n_acc  = 0;
   int at;
   int acc_base;
   logic [7:0][63:0] wdata;

   bank_cmd_scheduler dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .req_valid_in   (req_valid_in),
      .req_ready_out  (req_ready_out),
      .req_write_in   (req_write_in),
      .req_addr_in    (req_addr_in),
      .req_data_in    (req_data_in),
      .bank_group_out (bank_group_out),
      .bank_out       (bank_out),
      .row_out        (row_out),
      .col_out        (col_out),
      .cmd_out        (cmd_out),
      .valid_out      (valid_out),
      .val_out        (val_out),
      .hit_count_out  (hit_count_out),
      .miss_count_out (miss_count_out)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      if (req_valid_in && req_ready_out) n_acc++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge clk_in);
      cyc++;
      if (valid_out) ncmd++;
   endtask

   task automatic next_cmd(input int budget, output int when);
      when = -1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (valid_out) begin
            when = cyc;
            break;
         end
      end
   endtask

   task automatic wait_ready(input int budget, output int when);
      when = -1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (req_ready_out) begin
            when = cyc;
            break;
         end
      end
   endtask

   // Called at a negedge with ready high; returns 1 ns after the accept edge (cycle 0).
   task automatic issue(input logic wr, input logic [18:0] a, input logic [7:0][63:0] d);
      req_write_in = wr;
      req_addr_in  = a;
      req_data_in  = d;
      req_valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      req_valid_in = 1'b0;
      req_addr_in  = 19'h7FFFF;
      req_write_in = ~wr;
      cyc  = 0;
      ncmd = 0;
   endtask

   initial begin
      rst_in       = 1'b1;
      req_valid_in = 1'b0;
      req_write_in = 1'b0;
      req_addr_in  = '0;
      req_data_in  = '0;
      for (int i = 0; i < 8; i++) wdata[i] = 64'(i);
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;

      chk("rst_ready", 64'(req_ready_out), 64'd1);
      chk("rst_valid", 64'(valid_out), 64'd0);
      chk("rst_cmd",   64'(cmd_out), 64'd7);
      chk("rst_addr",  64'({bank_group_out, bank_out, row_out, col_out}), 64'd0);
      chk("rst_val",   val_out[0] | val_out[7], 64'd0);
      chk("rst_cnt",   {hit_count_out, miss_count_out}, 64'd0);
      step();
      chk("idle_nop",  64'({valid_out, cmd_out}), 64'({1'b0, 3'd7}));

      // 1: cold read row1 bank0 col1
      issue(1'b0, 19'h00204, '0);
      next_cmd(5, at);
      chk("t1_act_at",  64'(at), 64'd1);
      chk("t1_act_cmd", 64'(cmd_out), 64'd2);
      chk("t1_act_row", 64'(row_out), 64'd1);
      chk("t1_miss",    64'(miss_count_out), 64'd1);
      next_cmd(20, at);
      chk("t1_rd_at",   64'(at), 64'd9);
      chk("t1_rd_cmd",  64'(cmd_out), 64'd0);
      chk("t1_rd_col",  64'(col_out), 64'd1);
      chk("t1_rd_bank", 64'({bank_group_out, bank_out}), 64'd0);
      wait_ready(40, at);
      chk("t1_ready_at", 64'(at), 64'd39);
      chk("t1_ncmd",     64'(ncmd), 64'd2);

      // 2: row hit
      issue(1'b0, 19'h00208, '0);
      next_cmd(5, at);
      chk("t2_rd_at",  64'(at), 64'd1);
      chk("t2_rd_cmd", 64'(cmd_out), 64'd0);
      chk("t2_rd_col", 64'(col_out), 64'd2);
      chk("t2_hit",    64'(hit_count_out), 64'd1);
      wait_ready(40, at);
      chk("t2_ready_at", 64'(at), 64'd31);
      chk("t2_ncmd",     64'(ncmd), 64'd1);

      // 3: row conflict in bank0
      issue(1'b0, 19'h00404, '0);
      next_cmd(5, at);
      chk("t3_pre_at",  64'(at), 64'd1);
      chk("t3_pre_cmd", 64'(cmd_out), 64'd3);
      chk("t3_miss",    64'(miss_count_out), 64'd2);
      next_cmd(10, at);
      chk("t3_act_at",  64'(at), 64'd6);
      chk("t3_act",     64'({cmd_out, row_out}), 64'({3'd2, 8'd2}));
      next_cmd(12, at);
      chk("t3_rd_at",   64'(at), 64'd14);
      chk("t3_rd",      64'({cmd_out, col_out}), 64'({3'd0, 4'd1}));
      wait_ready(40, at);
      chk("t3_ready_at", 64'(at), 64'd44);

      // 4: write to closed bank1
      issue(1'b1, 19'h00044, wdata);
      next_cmd(5, at);
      chk("t4_act_at",  64'(at), 64'd1);
      chk("t4_act",     64'({cmd_out, bank_group_out, bank_out, row_out}), 64'({3'd2, 1'b0, 2'd1, 8'd0}));
      next_cmd(12, at);
      chk("t4_wr_at",   64'(at), 64'd9);
      chk("t4_wr",      64'({cmd_out, col_out}), 64'({3'd1, 4'd1}));
      for (int i = 0; i < 8; i++) chk($sformatf("t4_val%0d", i), val_out[i], 64'(i));
      while (cyc < 16) step();
      chk("t4_val_hold", val_out[3] ^ val_out[6], 64'd5);
      wait_ready(20, at);
      chk("t4_ready_at", 64'(at), 64'd17);
      chk("t4_miss",     64'(miss_count_out), 64'd3);

      // 5: reset during WAIT_ACT, then re-read bank0 row2
      issue(1'b0, 19'h000C4, '0);
      next_cmd(5, at);
      chk("t5_act_at", 64'(at), 64'd1);
      repeat (3) step();
      rst_in = 1'b1;
      #1;
      chk("t5_rst_cmd",   64'({valid_out, cmd_out}), 64'({1'b0, 3'd7}));
      chk("t5_rst_ready", 64'(req_ready_out), 64'd1);
      chk("t5_rst_cnt",   {hit_count_out, miss_count_out}, 64'd0);
      @(negedge clk_in);
      rst_in = 1'b0;
      issue(1'b0, 19'h00404, '0);
      next_cmd(5, at);
      chk("t5_reread_at",  64'(at), 64'd1);
      chk("t5_reread_act", 64'({cmd_out, row_out}), 64'({3'd2, 8'd2}));
      chk("t5_miss",       64'(miss_count_out), 64'd1);
      wait_ready(50, at);
      chk("t5_ready_at",   64'(at), 64'd39);

      // 7: bits above the row field are ignored (row2 col2, hit)
      issue(1'b0, 19'h60408, '0);
      next_cmd(5, at);
      chk("t7_rd_at", 64'(at), 64'd1);
      chk("t7_rd",    64'({cmd_out, row_out, col_out}), 64'({3'd0, 8'd2, 4'd2}));
      chk("t7_hit",   64'(hit_count_out), 64'd1);
      wait_ready(40, at);
      chk("t7_ready_at", 64'(at), 64'd31);

      // 6: valid held high through a whole read
      acc_base     = n_acc;
      req_write_in = 1'b0;
      req_addr_in  = 19'h00408;
      req_valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      cyc  = 0;
      ncmd = 0;
      wait_ready(40, at);
      req_valid_in = 1'b0;
      chk("t6_ready_at", 64'(at), 64'd31);
      chk("t6_accepts",  64'(n_acc - acc_base), 64'd1);
      chk("t6_ncmd",     64'(ncmd), 64'd1);
      chk("t6_hit",      64'(hit_count_out), 64'd2);
      repeat (3) step();
      chk("t6_accepts_after", 64'(n_acc - acc_base), 64'd1);
      chk("t6_ncmd_after",    64'(ncmd), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
